// File: rtl/ram_tdp_pkg.sv
// Shared constants for the parametrised true-dual-port RAM.
package ram_tdp_pkg;

    // Same-port read-during-write behaviour selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Deepest supported output register pipeline
    localparam int MAX_OUT_REGS    = 3;

endpackage

// File: rtl/ram_out_pipe.sv
// {valid,data} output pipeline: valid shifts every cycle, data only loads
// behind a valid slot so the output holds its last value across bubbles.
module ram_out_pipe #(
    parameter int DATA_W = 36,
    parameter int STAGES = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    if (STAGES == 0) begin : g_bypass
        // Array output register is the last stage; clock/reset not needed here
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ reset_i;
        assign vld_o  = vld_i;
        assign data_o = data_i;
    end else begin : g_pipe
        logic [STAGES-1:0]             vld_q;
        logic [STAGES-1:0][DATA_W-1:0] data_q;

        // Shift valids unconditionally; data stages advance only with a valid slot
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                vld_q  <= '0;
                data_q <= '0;
            end else begin
                vld_q[0] <= vld_i;
                if (vld_i) data_q[0] <= data_i;
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) data_q[s] <= data_q[s-1];
                end
            end
        end

        assign vld_o  = vld_q[STAGES-1];
        assign data_o = data_q[STAGES-1];
    end

endmodule

// File: rtl/ram_tdp_param_out_pipe.sv
// Single-clock true-dual-port RAM with byte-lane writes, selectable
// same-port read-during-write mode, A-priority on write collisions and a
// configurable output pipeline with read-valid tracking.
module ram_tdp_param_out_pipe
    import ram_tdp_pkg::*;
#(
    parameter  int DATA_W   = 36,
    parameter  int ADDR_W   = 10,
    parameter  int BYTE_W   = 9,
    parameter  int OUT_REGS = 1,
    parameter  int RDW_MODE = 0,
    localparam int BE_W     = DATA_W / BYTE_W
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              enA,
    input  logic              weA,
    input  logic [BE_W-1:0]   beA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] dinA,
    input  logic              enB,
    input  logic              weB,
    input  logic [BE_W-1:0]   beB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dinB,
    output logic [DATA_W-1:0] doutA,
    output logic [DATA_W-1:0] doutB,
    output logic              rvalidA,
    output logic              rvalidB,
    output logic              collision
);

    localparam int DEPTH = 1 << ADDR_W;

    if (DATA_W % BYTE_W != 0) begin : g_err_bytew
        $error("DATA_W must be a multiple of BYTE_W");
    end
    if (OUT_REGS < 0 || OUT_REGS > MAX_OUT_REGS) begin : g_err_outregs
        $error("OUT_REGS must be 0..3");
    end
    if (RDW_MODE < 0 || RDW_MODE > RDW_NO_CHANGE) begin : g_err_rdw
        $error("RDW_MODE must be 0..2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] maskA, maskB, oldA, oldB, mrgA, mrgB;
    logic              vldA_d, vldA_q, vldB_d, vldB_q;
    logic [DATA_W-1:0] dataA_d, dataA_q, dataB_d, dataB_q;
    logic              col_d, col_q;

    assign oldA = mem[addrA];
    assign oldB = mem[addrB];

    // Expand byte enables to bit masks and form each port's merged word
    always_comb begin
        maskA = '0;
        maskB = '0;
        for (int i = 0; i < BE_W; i++) begin
            maskA[i*BYTE_W +: BYTE_W] = {BYTE_W{beA[i]}};
            maskB[i*BYTE_W +: BYTE_W] = {BYTE_W{beB[i]}};
        end
        mrgA = (oldA & ~maskA) | (dinA & maskA);
        mrgB = (oldB & ~maskB) | (dinB & maskB);
    end

    // Lane writes; A is applied last so it wins overlapping lanes at one address
    always_ff @(posedge clock0) begin
        if (!reset) begin
            for (int i = 0; i < BE_W; i++) begin
                if (enB && weB && beB[i]) mem[addrB][i*BYTE_W +: BYTE_W] <= dinB[i*BYTE_W +: BYTE_W];
                if (enA && weA && beA[i]) mem[addrA][i*BYTE_W +: BYTE_W] <= dinA[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array-stage result per port: reads return the pre-edge word, writes follow RDW_MODE
    always_comb begin
        vldA_d  = 1'b0;
        dataA_d = dataA_q;
        vldB_d  = 1'b0;
        dataB_d = dataB_q;
        if (enA) begin
            if (!weA) begin
                vldA_d = 1'b1; dataA_d = oldA;
            end else if (RDW_MODE == RDW_READ_FIRST) begin
                vldA_d = 1'b1; dataA_d = oldA;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                vldA_d = 1'b1; dataA_d = mrgA;
            end
        end
        if (enB) begin
            if (!weB) begin
                vldB_d = 1'b1; dataB_d = oldB;
            end else if (RDW_MODE == RDW_READ_FIRST) begin
                vldB_d = 1'b1; dataB_d = oldB;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                vldB_d = 1'b1; dataB_d = mrgB;
            end
        end
        col_d = enA && weA && enB && weB && (addrA == addrB);
    end

    // Array output registers and collision flag
    always_ff @(posedge clock0) begin
        if (reset) begin
            vldA_q  <= 1'b0;
            vldB_q  <= 1'b0;
            dataA_q <= '0;
            dataB_q <= '0;
            col_q   <= 1'b0;
        end else begin
            vldA_q  <= vldA_d;
            vldB_q  <= vldB_d;
            dataA_q <= dataA_d;
            dataB_q <= dataB_d;
            col_q   <= col_d;
        end
    end

    assign collision = col_q;

    ram_out_pipe #(.DATA_W(DATA_W), .STAGES(OUT_REGS)) u_pipe_a (
        .clk_i(clock0), .reset_i(reset), .vld_i(vldA_q), .data_i(dataA_q),
        .vld_o(rvalidA), .data_o(doutA)
    );

    ram_out_pipe #(.DATA_W(DATA_W), .STAGES(OUT_REGS)) u_pipe_b (
        .clk_i(clock0), .reset_i(reset), .vld_i(vldB_q), .data_i(dataB_q),
        .vld_o(rvalidB), .data_o(doutB)
    );

endmodule

// File: tb/tb_ram_tdp_param_out_pipe.sv
// Three RAM instances share one stimulus stream: d0 OUT_REGS=2 READ_FIRST,
// d1 OUT_REGS=0 WRITE_FIRST, d2 OUT_REGS=3 NO_CHANGE. A word-level model
// predicts every output slot; directed sequences add fixed-value checks.
module tb_ram_tdp_param_out_pipe;

    typedef struct packed {
        logic        v;
        logic [35:0] d;
    } item_t;

    localparam int LAT [3] = '{2, 0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [3:0]  bea = '0, beb = '0;
    logic [9:0]  aa = '0, ab = '0;
    logic [35:0] da = '0, db = '0;

    logic [35:0] doa [3];
    logic [35:0] dob [3];
    logic        rva [3];
    logic        rvb [3];
    logic        col [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_tdp_param_out_pipe #(
            .DATA_W(36), .ADDR_W(10), .BYTE_W(9),
            .OUT_REGS((g == 0) ? 2 : (g == 1) ? 0 : 3),
            .RDW_MODE(g)
        ) u_dut (
            .clock0(clk), .reset(rst),
            .enA(ena), .weA(wea), .beA(bea), .addrA(aa), .dinA(da),
            .enB(enb), .weB(web), .beB(beb), .addrB(ab), .dinB(db),
            .doutA(doa[g]), .doutB(dob[g]), .rvalidA(rva[g]), .rvalidB(rvb[g]),
            .collision(col[g])
        );
    end

    // Reference model state
    logic [35:0] mm [1024];
    item_t       sh [3][2][4];
    logic [35:0] exp_do [3][2];
    logic        exp_rv [3][2];
    logic        exp_col  = 1'b0;
    logic        rst_prev = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] din,
                                          input logic [3:0] be);
        logic [35:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*9 +: 9] = din[i*9 +: 9];
        return r;
    endfunction

    // What a port's access produces at the output, by mode (0 RF, 1 WF, 2 NC)
    function automatic item_t outcome(input logic e, input logic w, input logic [35:0] old,
                                      input logic [35:0] newv, input int mode);
        item_t it;
        it = '0;
        if (e && !w)              it = '{1'b1, old};
        else if (e && mode == 0)  it = '{1'b1, old};
        else if (e && mode == 1)  it = '{1'b1, newv};
        return it;
    endfunction

    // One cycle: check outputs against the model, then model and drive the next access
    task automatic step(input logic r,
                        input logic e_a, input logic w_a, input logic [3:0] b_a,
                        input logic [9:0] a_a, input logic [35:0] d_a,
                        input logic e_b, input logic w_b, input logic [3:0] b_b,
                        input logic [9:0] a_b, input logic [35:0] d_b);
        item_t       it;
        logic [35:0] old_a, old_b;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (rst_prev) begin
                    for (int i = 0; i < 4; i++) sh[d][p][i] = '0;
                    exp_do[d][p] = '0;
                end
                it = sh[d][p][0];
                for (int i = 0; i < 3; i++) sh[d][p][i] = sh[d][p][i+1];
                sh[d][p][3] = '0;
                exp_rv[d][p] = it.v;
                if (it.v) exp_do[d][p] = it.d;
            end
            chk($sformatf("d%0d rvalidA", d), {35'd0, rva[d]}, {35'd0, exp_rv[d][0]});
            chk($sformatf("d%0d doutA", d), doa[d], exp_do[d][0]);
            chk($sformatf("d%0d rvalidB", d), {35'd0, rvb[d]}, {35'd0, exp_rv[d][1]});
            chk($sformatf("d%0d doutB", d), dob[d], exp_do[d][1]);
            chk($sformatf("d%0d collision", d), {35'd0, col[d]}, {35'd0, exp_col});
        end
        exp_col = 1'b0;
        if (!r) begin
            old_a = mm[a_a];
            old_b = mm[a_b];
            for (int d = 0; d < 3; d++) begin
                sh[d][0][LAT[d]] = outcome(e_a, w_a, old_a, merge(old_a, d_a, b_a), d);
                sh[d][1][LAT[d]] = outcome(e_b, w_b, old_b, merge(old_b, d_b, b_b), d);
            end
            exp_col = e_a && w_a && e_b && w_b && (a_a == a_b);
            if (e_b && w_b) mm[a_b] = merge(mm[a_b], d_b, b_b);
            if (e_a && w_a) mm[a_a] = merge(mm[a_a], d_a, b_a);
        end
        rst_prev = r;
        rst = r;
        ena = e_a; wea = w_a; bea = b_a; aa = a_a; da = d_a;
        enb = e_b; web = w_b; beb = b_b; ab = a_b; db = d_b;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
    endtask

    task automatic wr_a(input logic [9:0] a, input logic [35:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, 1'b1, be, a, d, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
    endtask

    task automatic rd_a(input logic [9:0] a);
        step(1'b0, 1'b1, 1'b0, 4'h0, a, 36'd0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
    endtask

    task automatic rd_b(input logic [9:0] a);
        step(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0, 1'b1, 1'b0, 4'h0, a, 36'd0);
    endtask

    function automatic logic [9:0] win(input int i);
        return (i < 16) ? 10'(i) : 10'(1008 + i - 16);
    endfunction

    function automatic logic [35:0] rnd36();
        logic [31:0] r0, r1;
        r0 = $urandom;
        r1 = $urandom;
        return {r1[3:0], r0};
    endfunction

    initial begin
        logic [3:0] rb_a, rb_b;
        // Reset: outputs cleared while reset is held and just after release
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
        chk("reset doutA", doa[0], 36'd0);
        chk("reset rvalidA", {35'd0, rva[0]}, 36'd0);
        idle(1);
        chk("post-reset rvalidA", {35'd0, rva[0]}, 36'd0);

        // Initialise the address window used by all later traffic
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 1'b1, 4'hF, win(i), rnd36(), 1'b1, 1'b1, 4'hF, win(i + 16), rnd36());
        idle(4);

        // Latency with OUT_REGS=2: valid exactly three cycles after the read is issued
        wr_a(10'd5, 36'h1_2345_6789, 4'hF);
        idle(4);
        rd_a(10'd5);
        idle(2);
        chk("lat early rvalidA", {35'd0, rva[0]}, 36'd0);
        idle(1);
        chk("lat rvalidA", {35'd0, rva[0]}, 36'd1);
        chk("lat doutA", doa[0], 36'h1_2345_6789);

        // Byte lanes 0 and 2 cleared: ones remain in bits 9..17 and 27..35
        wr_a(10'd7, 36'hF_FFFF_FFFF, 4'hF);
        wr_a(10'd7, 36'd0, 4'b0101);
        rd_a(10'd7);
        idle(3);
        chk("lanes doutA", doa[0], 36'hF_F803_FE00);

        // Same-port read-during-write per mode
        wr_a(10'd3, 36'hA, 4'hF);
        wr_a(10'd3, 36'hB, 4'hF);
        idle(1);
        chk("wf rvalidA", {35'd0, rva[1]}, 36'd1);
        chk("wf doutA", doa[1], 36'hB);
        idle(2);
        chk("rf rvalidA", {35'd0, rva[0]}, 36'd1);
        chk("rf doutA", doa[0], 36'hA);
        idle(1);
        chk("nc rvalidA", {35'd0, rva[2]}, 36'd0);
        chk("nc doutA hold", doa[2], 36'hF_F803_FE00);

        // Collision: A wins on full overlap, B fills lanes A does not enable
        step(1'b0, 1'b1, 1'b1, 4'hF, 10'd9, 36'h111, 1'b1, 1'b1, 4'hF, 10'd9, 36'h222);
        idle(1);
        chk("collision pulse", {35'd0, col[0]}, 36'd1);
        idle(1);
        chk("collision end", {35'd0, col[0]}, 36'd0);
        rd_a(10'd9);
        idle(3);
        chk("collision A wins", doa[0], 36'h111);
        step(1'b0, 1'b1, 1'b1, 4'b0001, 10'd9, 36'h333, 1'b1, 1'b1, 4'hF, 10'd9, 36'h444);
        rd_b(10'd9);
        idle(3);
        chk("collision lane merge", dob[0], 36'h533);

        // Cross-port: B reading while A writes sees the old word
        wr_a(10'd4, 36'h0, 4'hF);
        step(1'b0, 1'b1, 1'b1, 4'hF, 10'd4, 36'h55, 1'b1, 1'b0, 4'h0, 10'd4, 36'd0);
        idle(1);
        chk("cross old", dob[1], 36'h0);
        rd_b(10'd4);
        idle(1);
        chk("cross new", dob[1], 36'h55);
        idle(3);

        // Reset mid-flight on the OUT_REGS=3 instance: nothing emerges afterwards
        rd_a(10'd5);
        rd_a(10'd5);
        rd_a(10'd5);
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0, 1'b0, 1'b0, 4'h0, 10'd0, 36'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("flight rvalidA", {35'd0, rva[2]}, 36'd0);
        end
        rd_a(10'd5);
        idle(3);
        chk("mem kept", doa[0], 36'h1_2345_6789);

        // Random traffic over the window, occasional reset
        for (int n = 0; n < 600; n++) begin
            rb_a = 4'($urandom);
            rb_b = 4'($urandom);
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), rb_a,
                 win(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31)), rnd36(),
                 $urandom_range(0, 3) != 0, 1'($urandom), rb_b,
                 win(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31)), rnd36());
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
